// File: rtl/sample_window_if.sv
// Frame handshake bundle between the sample window and its downstream consumer.
interface sample_window_if #(
  parameter int unsigned OUT_W = 18,
  parameter int unsigned DEPTH = 16
);
  logic [DEPTH*OUT_W-1:0] window;
  logic                   frame_valid;
  logic                   frame_ready;

  modport master (
    output window,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  window,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/sample_window.sv
// Decimating, optionally averaging sample window with a valid/ready frame handshake and hop control.
module sample_window #(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned OUT_W    = 18,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DIV      = 5000,
  parameter int unsigned AVG_LOG2 = 0,
  parameter int unsigned HOP      = 16
) (
  input  logic                         clk_25,
  input  logic                         rst,
  input  logic [IN_W-1:0]              adc_sample,
  input  logic                         freeze,
  output logic                         sample_tick,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         overrun,
  sample_window_if.master              frm
);

  localparam int unsigned DIV_W  = $clog2(DIV);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned HOP_W  = $clog2(HOP + 1);
  localparam int unsigned ACC_W  = IN_W + AVG_LOG2;
  localparam int unsigned AVG_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned PAD    = OUT_W - IN_W;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [AVG_W-1:0]  AVG_LAST  = AVG_W'((1 << AVG_LOG2) - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [HOP_W-1:0]  HOP_FULL  = HOP_W'(HOP);

  typedef enum logic {
    ST_COLLECT,
    ST_FRAME
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [ACC_W-1:0]    acc_q;
  logic [AVG_W-1:0]    avg_q;
  logic [FILL_W-1:0]   fill_q;
  logic [HOP_W-1:0]    hop_q;
  logic                overrun_q;
  logic [OUT_W-1:0]    slot_q [DEPTH];

  logic [ACC_W-1:0]       sum_c;
  logic                   push_c;
  logic                   accept_c;
  logic                   handshake_c;
  logic [OUT_W-1:0]       result_c;
  logic [FILL_W-1:0]      fill_inc_c;
  logic [HOP_W-1:0]       hop_inc_c;
  logic [DEPTH*OUT_W-1:0] window_c;

  // Tick is combinational on freeze so a frozen cycle never ticks even at the terminal count.
  assign sample_tick = !freeze && (div_q == DIV_LAST);

  assign sum_c       = acc_q + ACC_W'(adc_sample);
  assign push_c      = sample_tick && (avg_q == AVG_LAST);
  assign result_c    = OUT_W'(IN_W'(sum_c >> AVG_LOG2)) << PAD;
  assign accept_c    = push_c && (state_q == ST_COLLECT);
  assign handshake_c = (state_q == ST_FRAME) && frm.frame_ready;
  assign fill_inc_c  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign hop_inc_c   = (hop_q == HOP_FULL) ? hop_q : hop_q + HOP_W'(1);

  // Sample-rate divider; holds while frozen.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (!freeze) begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  // Averaging accumulator; keeps running even while pushes are being dropped.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      avg_q <= '0;
    end else if (sample_tick) begin
      if (avg_q == AVG_LAST) begin
        acc_q <= '0;
        avg_q <= '0;
      end else begin
        acc_q <= sum_c;
        avg_q <= avg_q + AVG_W'(1);
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame next-state: issue when an accepted push completes fill and hop, retire on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept_c && (fill_inc_c == FILL_FULL) && (hop_inc_c == HOP_FULL)) begin
          state_d = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (frm.frame_ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Fill/hop bookkeeping and sticky overrun for pushes that land on a pending frame.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      fill_q    <= '0;
      hop_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept_c) begin
        fill_q <= fill_inc_c;
      end
      if (handshake_c) begin
        hop_q <= '0;
      end else if (accept_c) begin
        hop_q <= hop_inc_c;
      end
      if (push_c && (state_q == ST_FRAME)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Window shift register; frozen while a frame is pending so the consumer sees stable data.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else if (accept_c) begin
      slot_q[0] <= result_c;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        slot_q[k] <= slot_q[k-1];
      end
    end
  end

  // Flatten slots onto the window bus, slot 0 in the low bits.
  always_comb begin
    window_c = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      window_c[k*OUT_W +: OUT_W] = slot_q[k];
    end
  end

  assign frm.window      = window_c;
  assign frm.frame_valid = (state_q == ST_FRAME);
  assign fill_count      = fill_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_sample_window.sv
// Bench for sample_window: vector table with scoreboard queue plus hand-written corner sequences.
module tb_sample_window;

  logic        clk_25;
  logic        rst;
  logic [11:0] adc;
  logic        freeze;
  logic        tick;
  logic [2:0]  fill;
  logic        ovr;

  logic        rst_a;
  logic [11:0] adc_a;
  logic        tick_a;
  logic [2:0]  fill_a;
  logic        ovr_a;

  int checks;
  int failures;

  sample_window_if #(.OUT_W(18), .DEPTH(4)) frm_if ();
  sample_window_if #(.OUT_W(18), .DEPTH(4)) frm_a ();

  sample_window #(
    .IN_W(12), .OUT_W(18), .DEPTH(4), .DIV(4), .AVG_LOG2(0), .HOP(2)
  ) dut (
    .clk_25(clk_25), .rst(rst), .adc_sample(adc), .freeze(freeze),
    .sample_tick(tick), .fill_count(fill), .overrun(ovr), .frm(frm_if)
  );

  sample_window #(
    .IN_W(12), .OUT_W(18), .DEPTH(4), .DIV(4), .AVG_LOG2(2), .HOP(2)
  ) dut_avg (
    .clk_25(clk_25), .rst(rst_a), .adc_sample(adc_a), .freeze(1'b0),
    .sample_tick(tick_a), .fill_count(fill_a), .overrun(ovr_a), .frm(frm_a)
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  typedef struct {
    logic [11:0] adc;
    logic [2:0]  fill;
    logic        valid;
    logic        ovr;
    logic [71:0] win;
  } vec_t;

  vec_t tbl [13];
  vec_t sb_q [$];

  function automatic logic [71:0] mkwin(input int s0, input int s1, input int s2, input int s3);
    return {18'(s3), 18'(s2), 18'(s1), 18'(s0)};
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, 80'({frm_if.window, frm_if.frame_valid, tick, fill, ovr}), 80'(0));
  endtask

  // Drive one sample, wait for its tick, then compare the post-push state against the scoreboard.
  task automatic run_tick(input vec_t v, input int exp_wait);
    int   waited;
    vec_t e;
    adc = v.adc;
    sb_q.push_back(v);
    waited = 0;
    while (!tick && waited < 20) begin
      @(negedge clk_25);
      waited++;
    end
    chk("tick_seen", 80'(tick), 80'(1));
    if (exp_wait >= 0) chk("tick_spacing", 80'(waited), 80'(exp_wait));
    @(negedge clk_25);
    chk("tick_width", 80'(tick), 80'(0));
    e = sb_q.pop_front();
    chk("fill_count", 80'(fill), 80'(e.fill));
    chk("frame_valid", 80'(frm_if.frame_valid), 80'(e.valid));
    chk("overrun", 80'(ovr), 80'(e.ovr));
    chk("window", 80'(frm_if.window), 80'(e.win));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int waited;
    checks   = 0;
    failures = 0;
    rst    = 1'b1;
    adc    = '0;
    freeze = 1'b0;
    frm_if.frame_ready = 1'b0;
    rst_a  = 1'b1;
    adc_a  = '0;
    frm_a.frame_ready = 1'b0;

    tbl[0]  = '{12'd1,  3'd1, 1'b0, 1'b0, mkwin(64, 0, 0, 0)};
    tbl[1]  = '{12'd2,  3'd2, 1'b0, 1'b0, mkwin(128, 64, 0, 0)};
    tbl[2]  = '{12'd3,  3'd3, 1'b0, 1'b0, mkwin(192, 128, 64, 0)};
    tbl[3]  = '{12'd4,  3'd4, 1'b1, 1'b0, mkwin(256, 192, 128, 64)};
    tbl[4]  = '{12'd5,  3'd4, 1'b1, 1'b1, mkwin(256, 192, 128, 64)};
    tbl[5]  = '{12'd6,  3'd4, 1'b1, 1'b1, mkwin(256, 192, 128, 64)};
    tbl[6]  = '{12'd7,  3'd4, 1'b0, 1'b1, mkwin(448, 256, 192, 128)};
    tbl[7]  = '{12'd8,  3'd4, 1'b1, 1'b1, mkwin(512, 448, 256, 192)};
    tbl[8]  = '{12'd9,  3'd4, 1'b1, 1'b1, mkwin(512, 448, 256, 192)};
    tbl[9]  = '{12'd10, 3'd1, 1'b0, 1'b0, mkwin(640, 0, 0, 0)};
    tbl[10] = '{12'd11, 3'd2, 1'b0, 1'b0, mkwin(704, 640, 0, 0)};
    tbl[11] = '{12'd12, 3'd3, 1'b0, 1'b0, mkwin(768, 704, 640, 0)};
    tbl[12] = '{12'd13, 3'd4, 1'b1, 1'b0, mkwin(832, 768, 704, 640)};

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk_25);
      chk_zero("reset_hold");
    end
    @(posedge clk_25);
    #1 rst = 1'b0;
    @(negedge clk_25);

    // Fill to first frame, then backpressure drops two pushes
    for (int i = 0; i < 6; i++) run_tick(tbl[i], 3);

    // One-cycle ready pulse retires the frame and the hop count
    frm_if.frame_ready = 1'b1;
    @(negedge clk_25);
    frm_if.frame_ready = 1'b0;
    chk("handshake_valid", 80'(frm_if.frame_valid), 80'(0));
    chk("handshake_window", 80'(frm_if.window), 80'(mkwin(256, 192, 128, 64)));
    run_tick(tbl[6], 2);
    run_tick(tbl[7], 3);

    // Freeze mid-count: no ticks, divider resumes with the remaining count
    @(negedge clk_25);
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_25);
      chk("freeze_no_tick", 80'(tick), 80'(0));
    end
    freeze = 1'b0;
    chk("freeze_window", 80'(frm_if.window), 80'(mkwin(512, 448, 256, 192)));
    run_tick(tbl[8], 2);

    // Asynchronous reset between edges with a frame pending and overrun set
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    @(posedge clk_25);
    #1 rst = 1'b0;
    @(negedge clk_25);
    for (int i = 9; i < 13; i++) run_tick(tbl[i], 3);

    // Averaging instance: four readings make exactly one push
    @(posedge clk_25);
    #1 rst_a = 1'b0;
    @(negedge clk_25);
    for (int i = 0; i < 4; i++) begin
      adc_a = 12'(100 + i);
      waited = 0;
      while (!tick_a && waited < 20) begin
        @(negedge clk_25);
        waited++;
      end
      chk("avg_tick_spacing", 80'(waited), 80'(3));
      @(negedge clk_25);
      chk("avg_fill", 80'(fill_a), 80'((i == 3) ? 1 : 0));
      chk("avg_window", 80'(frm_a.window), 80'((i == 3) ? mkwin(6464, 0, 0, 0) : mkwin(0, 0, 0, 0)));
    end
    chk("avg_overrun", 80'(ovr_a), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
